// File: rtl/erx_frame_align.sv
// eLink RX word aligner: finds the frame rising edge among 8 samples per clock, locks the
// sample offset and emits 64-bit words aligned to frame start with SOP, error and statistics.
`timescale 1ns / 1ps

module erx_frame_align #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic [7:0]    frame_in,
    input  logic [63:0]   data_in,
    input  logic          clr_count,
    output logic [63:0]   data_out,
    output logic          valid_out,
    output logic          sop_out,
    output logic          locked,
    output logic [2:0]    align_offset,
    output logic          align_err,
    output logic [CW-1:0] frame_count,
    output logic [CW-1:0] err_count
);

    typedef enum logic {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [7:0]   s1_frame;
    logic [63:0]  s1_data;
    logic         s2_last;

    logic [127:0] win;
    logic [15:0]  fwin;
    logic [7:0]   rise;
    logic         edge_found;
    logic [2:0]   edge_p;
    logic [2:0]   sel_p;
    logic [63:0]  word;
    logic [7:0]   fpat;
    logic         emit;
    logic         emit_sop;
    logic         flag_err;

    assign win  = {data_in, s1_data};
    assign fwin = {frame_in, s1_frame};

    // Sample 0 of the previous cycle takes its predecessor from two cycles back.
    assign rise = s1_frame & ~{s1_frame[6:0], s2_last};

    always_comb begin
        edge_found = 1'b0;
        edge_p     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rise[i]) begin
                edge_found = 1'b1;
                edge_p     = 3'(i);
            end
        end
    end

    assign sel_p  = (state_q == StActive) ? align_offset : edge_p;
    assign word   = win[{sel_p, 3'b000} +: 64];
    assign fpat   = fwin[sel_p +: 8];
    assign locked = (state_q == StActive);

    // All-ones history so a frame already high at reset/enable never looks like a rising edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_frame <= 8'hFF;
            s2_last  <= 1'b1;
            s1_data  <= 64'd0;
        end else if (!en) begin
            s1_frame <= 8'hFF;
            s2_last  <= 1'b1;
            s1_data  <= 64'd0;
        end else begin
            s2_last  <= s1_frame[7];
            s1_frame <= frame_in;
            s1_data  <= data_in;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (edge_found && fpat == 8'hFF) state_d = StActive;
                StActive: if (fpat != 8'hFF) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_sop = 1'b0;
        flag_err = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (edge_found) begin
                        if (fpat == 8'hFF) begin
                            emit     = 1'b1;
                            emit_sop = 1'b1;
                        end else begin
                            flag_err = 1'b1;
                        end
                    end
                end
                StActive: begin
                    if (fpat == 8'hFF) begin
                        emit = 1'b1;
                    end else if (fpat != 8'h00) begin
                        flag_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data_out     <= 64'd0;
            valid_out    <= 1'b0;
            sop_out      <= 1'b0;
            align_err    <= 1'b0;
            align_offset <= 3'd0;
        end else begin
            valid_out <= emit;
            sop_out   <= emit_sop;
            align_err <= flag_err;
            if (emit) begin
                data_out <= word;
            end
            if (emit_sop) begin
                align_offset <= sel_p;
            end
        end
    end

    // Saturating statistics; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            frame_count <= '0;
            err_count   <= '0;
        end else if (clr_count) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (emit_sop && frame_count != '1) begin
                frame_count <= frame_count + CW'(1);
            end
            if (flag_err && err_count != '1) begin
                err_count <= err_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_erx_frame_align.sv
// Directed bench for erx_frame_align: a CW=16 and a CW=2 instance share the same stimulus.
`timescale 1ns / 1ps

module tb_erx_frame_align;

    logic        clk;
    logic        nreset;
    logic        en;
    logic [7:0]  frame_in;
    logic [63:0] data_in;
    logic        clr_count;

    logic [63:0] data_out, data_out2;
    logic        valid_out, valid_out2;
    logic        sop_out, sop_out2;
    logic        locked, locked2;
    logic [2:0]  align_offset, align_offset2;
    logic        align_err, align_err2;
    logic [15:0] frame_count, err_count;
    logic [1:0]  frame_count2, err_count2;

    int vectors;
    int miscompares;

    erx_frame_align #(.CW(16)) dut (
        .clk(clk), .nreset(nreset), .en(en), .frame_in(frame_in), .data_in(data_in),
        .clr_count(clr_count), .data_out(data_out), .valid_out(valid_out), .sop_out(sop_out),
        .locked(locked), .align_offset(align_offset), .align_err(align_err),
        .frame_count(frame_count), .err_count(err_count)
    );

    erx_frame_align #(.CW(2)) dut2 (
        .clk(clk), .nreset(nreset), .en(en), .frame_in(frame_in), .data_in(data_in),
        .clr_count(clr_count), .data_out(data_out2), .valid_out(valid_out2), .sop_out(sop_out2),
        .locked(locked2), .align_offset(align_offset2), .align_err(align_err2),
        .frame_count(frame_count2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] seq(input logic [7:0] b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = b + 8'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle and sample the outputs 1ns after the edge that closes it.
    task automatic cyc(input logic [7:0] f, input logic [63:0] d);
        frame_in = f;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic v, input logic s, input logic [63:0] d);
        chk({tag, ".valid"}, 64'(valid_out), 64'(v));
        chk({tag, ".sop"}, 64'(sop_out), 64'(s));
        if (v) chk({tag, ".data"}, data_out, d);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nreset      = 1'b0;
        en          = 1'b0;
        clr_count   = 1'b0;
        frame_in    = 8'h00;
        data_in     = 64'd0;
        #12;
        chk("rst.data", data_out, 64'd0);
        chk("rst.valid", 64'(valid_out), 64'd0);
        chk("rst.sop", 64'(sop_out), 64'd0);
        chk("rst.locked", 64'(locked), 64'd0);
        chk("rst.offset", 64'(align_offset), 64'd0);
        chk("rst.err", 64'(align_err), 64'd0);
        chk("rst.fcnt", 64'(frame_count), 64'd0);
        chk("rst.ecnt", 64'(err_count), 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        en     = 1'b1;

        // Aligned packet at offset 0
        cyc(8'h00, seq(8'hF0));  chk_word("al0", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h00));  chk_word("al1", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h08));  chk_word("al2", 1'b1, 1'b1, 64'h0706050403020100);
        chk("al2.locked", 64'(locked), 64'd1);
        chk("al2.offset", 64'(align_offset), 64'd0);
        chk("al2.fcnt", 64'(frame_count), 64'd1);
        cyc(8'hFF, seq(8'h10));  chk_word("al3", 1'b1, 1'b0, 64'h0F0E0D0C0B0A0908);
        cyc(8'h00, seq(8'h18));  chk_word("al4", 1'b1, 1'b0, 64'h1716151413121110);
        chk("al4.locked", 64'(locked), 64'd1);
        cyc(8'h00, seq(8'h20));  chk_word("al5", 1'b0, 1'b0, 64'd0);
        chk("al5.locked", 64'(locked), 64'd0);
        chk("al5.ecnt", 64'(err_count), 64'd0);

        // Offset 5
        cyc(8'hE0, seq(8'h30));  chk_word("of0", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h38));  chk_word("of1", 1'b1, 1'b1, 64'h3C3B3A3938373635);
        chk("of1.offset", 64'(align_offset), 64'd5);
        chk("of1.fcnt", 64'(frame_count), 64'd2);
        cyc(8'hFF, seq(8'h40));  chk_word("of2", 1'b1, 1'b0, 64'h44434241403F3E3D);
        cyc(8'h1F, seq(8'h48));  chk_word("of3", 1'b1, 1'b0, 64'h4C4B4A4948474645);
        chk("of3.err", 64'(align_err), 64'd0);
        cyc(8'h00, seq(8'h50));  chk_word("of4", 1'b0, 1'b0, 64'd0);
        chk("of4.locked", 64'(locked), 64'd0);
        chk("of4.ecnt", 64'(err_count), 64'd0);
        cyc(8'h00, seq(8'h58));  chk_word("of5", 1'b0, 1'b0, 64'd0);

        // Glitch while idle
        cyc(8'h10, 64'd0);       chk("gl0.err", 64'(align_err), 64'd0);
        cyc(8'h00, 64'd0);       chk("gl1.err", 64'(align_err), 64'd1);
        chk_word("gl1", 1'b0, 1'b0, 64'd0);
        chk("gl1.locked", 64'(locked), 64'd0);
        chk("gl1.ecnt", 64'(err_count), 64'd1);
        cyc(8'h00, 64'd0);       chk("gl2.err", 64'(align_err), 64'd0);
        chk("gl2.hold", data_out, 64'h4C4B4A4948474645);

        // Mid-packet framing violation, then relock
        cyc(8'hFF, seq(8'h60));  chk_word("mp0", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h68));  chk_word("mp1", 1'b1, 1'b1, 64'h6766656463626160);
        chk("mp1.offset", 64'(align_offset), 64'd0);
        cyc(8'h0F, seq(8'h70));  chk_word("mp2", 1'b1, 1'b0, 64'h6F6E6D6C6B6A6968);
        cyc(8'h00, seq(8'h78));  chk_word("mp3", 1'b0, 1'b0, 64'd0);
        chk("mp3.err", 64'(align_err), 64'd1);
        chk("mp3.locked", 64'(locked), 64'd0);
        chk("mp3.ecnt", 64'(err_count), 64'd2);
        cyc(8'hFF, seq(8'h80));  chk_word("mp4", 1'b0, 1'b0, 64'd0);
        chk("mp4.err", 64'(align_err), 64'd0);
        cyc(8'h00, seq(8'h88));  chk_word("mp5", 1'b1, 1'b1, 64'h8786858483828180);
        chk("mp5.fcnt", 64'(frame_count), 64'd4);
        cyc(8'h00, 64'd0);       chk("mp6.locked", 64'(locked), 64'd0);

        // Frame already high when enable rises
        en = 1'b0;
        cyc(8'hFF, seq(8'h90));  chk_word("en0", 1'b0, 1'b0, 64'd0);
        en = 1'b1;
        cyc(8'hFF, seq(8'h90));  chk_word("en1", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h90));  chk_word("en2", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h90));  chk_word("en3", 1'b0, 1'b0, 64'd0);
        chk("en3.err", 64'(align_err), 64'd0);
        cyc(8'h00, seq(8'h90));  chk_word("en4", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'h98));  chk_word("en5", 1'b0, 1'b0, 64'd0);
        cyc(8'h00, 64'd0);       chk_word("en6", 1'b1, 1'b1, 64'h9F9E9D9C9B9A9998);
        chk("en6.fcnt", 64'(frame_count), 64'd5);
        cyc(8'h00, 64'd0);       chk("en7.locked", 64'(locked), 64'd0);

        // Saturation of the narrow counters after 5 packets and 2 errors
        chk("sat.fcnt2", 64'(frame_count2), 64'd3);
        chk("sat.ecnt2", 64'(err_count2), 64'd2);

        // Clear coincident with a sop
        cyc(8'hFF, seq(8'hA0));  chk_word("clr0", 1'b0, 1'b0, 64'd0);
        clr_count = 1'b1;
        cyc(8'hFF, seq(8'hA8));  chk_word("clr1", 1'b1, 1'b1, 64'hA7A6A5A4A3A2A1A0);
        chk("clr1.fcnt", 64'(frame_count), 64'd0);
        chk("clr1.ecnt", 64'(err_count), 64'd0);
        chk("clr1.fcnt2", 64'(frame_count2), 64'd0);
        clr_count = 1'b0;
        cyc(8'hFF, seq(8'hB0));  chk_word("clr2", 1'b1, 1'b0, 64'hAFAEADACABAAA9A8);
        chk("clr2.fcnt", 64'(frame_count), 64'd0);

        // Asynchronous reset mid-packet, frame held high through release
        #3;
        nreset = 1'b0;
        #1;
        chk("ar.valid", 64'(valid_out), 64'd0);
        chk("ar.data", data_out, 64'd0);
        chk("ar.locked", 64'(locked), 64'd0);
        chk("ar.sop", 64'(sop_out), 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        cyc(8'hFF, seq(8'hB8));  chk_word("ar0", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'hB8));  chk_word("ar1", 1'b0, 1'b0, 64'd0);
        chk("ar1.locked", 64'(locked), 64'd0);
        cyc(8'h00, seq(8'hB8));  chk_word("ar2", 1'b0, 1'b0, 64'd0);
        cyc(8'hFF, seq(8'hC0));  chk_word("ar3", 1'b0, 1'b0, 64'd0);
        cyc(8'h00, 64'd0);       chk_word("ar4", 1'b1, 1'b1, 64'hC7C6C5C4C3C2C1C0);
        chk("ar4.fcnt", 64'(frame_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/erx_frame_align.md
Name: erx_frame_align

Overview:
- Word-alignment stage in the eLink RX path, clocked by rx_lclk_div4 and reset by erx_nreset from the RX clock/reset block.
- Consumes the 1:8 deserialized frame line and 8-bit data lanes, 8 samples per clock.
- Finds the frame rising edge, locks the sample offset, and emits 64-bit words aligned to the frame start, with start-of-packet marking, error flagging and saturating statistics.

Parameters:
CW  16  width of frame_count and err_count (saturating)

Ports:
clk          input   1     rx_lclk_div4
nreset       input   1     async active-low reset (erx_nreset)
en           input   1     align enable (rx_active); low forces IDLE, no output
frame_in     input   8     frame samples, bit k = sample k, sample 0 earliest
data_in      input   64    data samples, data_in[8k+7:8k] = byte sample k
clr_count    input   1     synchronous clear of both counters
data_out     output  64    aligned word, byte 0 = first byte of word
valid_out    output  1     data_out valid
sop_out      output  1     first word of packet (qualifies valid_out)
locked       output  1     state==ACTIVE
align_offset output  3     captured sample offset p
align_err    output  1     one-cycle pulse, framing violation
frame_count  output  CW    packets started (sop count), saturating
err_count    output  CW    align_err count, saturating

Behaviour:
- History regs: s1_frame[7:0] and s1_data[63:0] hold the previous cycle's inputs. s2_last holds frame_in[7] from two cycles ago.
- Reset/en-low values: s1_frame=8'hFF, s2_last=1, s1_data=0. Reset only: state IDLE, all outputs 0, counters 0.
- The all-ones history means a frame already high at reset or at enable is not a rising edge. It is ignored until it falls and rises again.
- Window: W = {data_in, s1_data} (128b, sample i = W[8i+7:8i], i=0..15). F = {frame_in, s1_frame}.
- Candidate word at offset p: bytes W samples p..p+7. Aligned frame bits: F[p+7:p].
- IDLE:
  - Rising edge at p in s1 means s1_frame[p]=1 and predecessor=0. The predecessor is s1_frame[p-1], or s2_last for p=0.
  - Multiple edges: lowest p wins.
  - On an edge with F[p+7:p]==8'hFF: offset<=p; emit the word with sop; go ACTIVE.
  - On an edge with the pattern not all-ones: pulse align_err; stay IDLE.
- ACTIVE, using the captured offset each cycle:
  - F[off+7:off]==8'hFF: emit word, sop=0.
  - F[off+7:off]==8'h00: packet end; no output; go IDLE.
  - Any mixed pattern: pulse align_err; no output; go IDLE.
- Output registered: data_out/valid_out/sop_out/align_err update on the clock edge ending the input cycle that supplies the word's last byte. Latency is 1 cycle.
- data_out holds its last value when valid_out=0.
- en low: state<=IDLE next edge; valid_out, sop_out and align_err are 0 from that edge. History regs are forced to reset values.
- Counters:
  - frame_count+1 on each sop emit; err_count+1 on each align_err.
  - Both saturate at all-ones.
  - clr_count wins over a simultaneous increment (result 0).
- align_offset holds the last captured p. It is 0 after reset.
- Async reset mid-packet: immediate IDLE, outputs 0. No partial word is emitted.

Test Plan:
- Aligned packet:
  - Stimulus: frame 0x00 in cycle 0, then 0xFF for 3 cycles, then 0x00; data bytes incrementing from 0x00.
  - Response: 3 valid words 0x0706050403020100, 0x0F0E…08, 0x17…10; sop on first only; align_offset=0; frame_count=1; locked drops after the 0x00 cycle.
- Offset 5:
  - Stimulus: frame 0xE0, 0xFF, 0xFF, 0x1F, 0x00.
  - Response: align_offset=5; 3 words, the first = bytes samples 5..12; no align_err.
- Glitch:
  - Stimulus: IDLE; frame 0x10 then 0x00.
  - Response: align_err one pulse; err_count=1; no valid_out; state IDLE.
- Mid-packet violation:
  - Stimulus: lock at offset 0, then frame 0x0F.
  - Response: align_err pulse; no word for that cycle; IDLE.
  - Stimulus: frame 0x00 then 0xFF.
  - Response: relock with sop.
- Frame high at reset release, or at en rise:
  - Stimulus: frame 0xFF continuous.
  - Response: no output.
  - Stimulus: frame 0x00 then 0xFF.
  - Response: valid sop.
- Counters:
  - Stimulus: CW=2 with 5 packets.
  - Response: frame_count=3 (saturated).
  - Stimulus: clr_count coincident with a sop.
  - Response: frame_count=0.
  - Stimulus: async nreset pulse mid-word.
  - Response: all outputs 0 immediately.
